// File: rtl/crypto_copro_offload_ctrl.sv
// Core-side offload controller for the crypto coprocessor issue/result protocol.
// Holds one instruction in flight from issue request to a single writeback pulse.
module crypto_copro_offload_ctrl #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  input  logic [3*XLEN-1:0]     rs_i,
  input  logic [2:0]            rs_valid_i,
  input  logic                  flush_i,
  output logic                  x_issue_valid_o,
  input  logic                  x_issue_ready_i,
  output logic [31:0]           x_issue_instr_o,
  output logic [ID_WIDTH-1:0]   x_issue_id_o,
  output logic [3*XLEN-1:0]     x_issue_rs_o,
  output logic [2:0]            x_issue_rs_valid_o,
  input  logic                  x_resp_accept_i,
  input  logic                  x_resp_writeback_i,
  input  logic [2:0]            x_resp_register_read_i,
  input  logic                  x_result_valid_i,
  output logic                  x_result_ready_o,
  input  logic [ID_WIDTH-1:0]   x_result_id_i,
  input  logic [XLEN-1:0]       x_result_data_i,
  output logic                  wb_valid_o,
  output logic [ID_WIDTH-1:0]   wb_id_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic [1:0]            wb_exc_o,
  output logic                  busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    DRAIN,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         instr_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [3*XLEN-1:0]   rs_q;
  logic [2:0]          rsv_q;
  logic [CW-1:0]       cnt_q;
  logic [ID_WIDTH-1:0] wb_id_q;
  logic [XLEN-1:0]     wb_data_q;
  logic [1:0]          wb_exc_q;

  logic                take, id_hit, tmo, opnd_miss;
  logic                cnt_clr, cnt_inc, wb_load;
  logic [1:0]          exc_d;
  logic [XLEN-1:0]     data_d;

  assign take      = (state_q == IDLE) & instr_valid_i;
  assign id_hit    = x_result_valid_i & (x_result_id_i == id_q);
  assign tmo       = cnt_q == CW'(TIMEOUT - 1);
  assign opnd_miss = |(x_resp_register_read_i & ~rsv_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    wb_load = 1'b0;
    exc_d   = 2'd0;
    data_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (instr_valid_i) state_d = ISSUE;
      end
      ISSUE: begin
        if (x_issue_ready_i) begin
          if (!x_resp_accept_i) begin
            state_d = DONE;
            wb_load = 1'b1;
            exc_d   = 2'd1;
          end else if (opnd_miss) begin
            state_d = DONE;
            wb_load = 1'b1;
            exc_d   = 2'd2;
          end else if (!x_resp_writeback_i) begin
            state_d = DONE;
            wb_load = 1'b1;
          end else begin
            state_d = WAIT_RES;
            cnt_clr = 1'b1;
          end
          // A flush racing the handshake only leaves work behind if a result is owed
          if (flush_i) begin
            wb_load = 1'b0;
            state_d = (state_d == WAIT_RES) ? DRAIN : IDLE;
          end
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT_RES: begin
        if (flush_i) begin
          state_d = id_hit ? IDLE : DRAIN;
          cnt_clr = 1'b1;
        end else if (id_hit) begin
          state_d = DONE;
          wb_load = 1'b1;
          data_d  = x_result_data_i;
        end else if (tmo) begin
          state_d = DONE;
          wb_load = 1'b1;
          exc_d   = 2'd3;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (id_hit || tmo) state_d = IDLE;
        else               cnt_inc = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q   <= '0;
      id_q      <= '0;
      rs_q      <= '0;
      rsv_q     <= '0;
      cnt_q     <= '0;
      wb_id_q   <= '0;
      wb_data_q <= '0;
      wb_exc_q  <= '0;
    end else begin
      if (take) begin
        instr_q <= instr_i;
        id_q    <= id_i;
        rs_q    <= rs_i;
        rsv_q   <= rs_valid_i;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CW'(1);
      if (wb_load) begin
        wb_id_q   <= id_q;
        wb_data_q <= data_d;
        wb_exc_q  <= exc_d;
      end
    end
  end

  assign instr_ready_o      = state_q == IDLE;
  assign busy_o             = state_q != IDLE;
  assign x_issue_valid_o    = state_q == ISSUE;
  assign x_issue_instr_o    = instr_q;
  assign x_issue_id_o       = id_q;
  assign x_issue_rs_o       = rs_q;
  assign x_issue_rs_valid_o = rsv_q;
  assign x_result_ready_o   = (state_q == WAIT_RES) | (state_q == DRAIN);
  assign wb_valid_o         = (state_q == DONE) & ~flush_i;
  assign wb_id_o            = wb_id_q;
  assign wb_data_o          = wb_data_q;
  assign wb_exc_o           = wb_exc_q;

endmodule

// File: tb/tb_crypto_copro_offload_ctrl.sv
// Transaction-level bench for crypto_copro_offload_ctrl.
// Driver predicts each writeback event; a monitor checks wb outputs every cycle.
module tb_crypto_copro_offload_ctrl;

  localparam int XLEN = 64;
  localparam int IDW  = 3;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic [31:0]     instr_i;
  logic [IDW-1:0]  id_i;
  logic [191:0]    rs_i;
  logic [2:0]      rs_valid_i;
  logic            flush_i;
  logic            x_issue_valid_o;
  logic            x_issue_ready_i;
  logic [31:0]     x_issue_instr_o;
  logic [IDW-1:0]  x_issue_id_o;
  logic [191:0]    x_issue_rs_o;
  logic [2:0]      x_issue_rs_valid_o;
  logic            x_resp_accept_i;
  logic            x_resp_writeback_i;
  logic [2:0]      x_resp_register_read_i;
  logic            x_result_valid_i;
  logic            x_result_ready_o;
  logic [IDW-1:0]  x_result_id_i;
  logic [63:0]     x_result_data_i;
  logic            wb_valid_o;
  logic [IDW-1:0]  wb_id_o;
  logic [63:0]     wb_data_o;
  logic [1:0]      wb_exc_o;
  logic            busy_o;

  crypto_copro_offload_ctrl #(
    .XLEN(XLEN), .ID_WIDTH(IDW), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .id_i(id_i), .rs_i(rs_i),
    .rs_valid_i(rs_valid_i), .flush_i(flush_i),
    .x_issue_valid_o(x_issue_valid_o),
    .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o),
    .x_issue_id_o(x_issue_id_o),
    .x_issue_rs_o(x_issue_rs_o),
    .x_issue_rs_valid_o(x_issue_rs_valid_o),
    .x_resp_accept_i(x_resp_accept_i),
    .x_resp_writeback_i(x_resp_writeback_i),
    .x_resp_register_read_i(x_resp_register_read_i),
    .x_result_valid_i(x_result_valid_i),
    .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i),
    .x_result_data_i(x_result_data_i),
    .wb_valid_o(wb_valid_o), .wb_id_o(wb_id_o),
    .wb_data_o(wb_data_o), .wb_exc_o(wb_exc_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [2:0]  id;
    logic [63:0] d;
    logic [1:0]  e;
  } wb_t;

  wb_t         exp_q[$];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  int          req_cyc;
  int          last_wb_cyc;
  logic [2:0]  last_id;
  logic [63:0] last_data;
  logic [1:0]  last_exc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: wb_valid_o must pulse exactly in the predicted cycles
  always @(negedge clk) begin
    if (rst_ni) begin
      if (wb_valid_o) begin
        last_wb_cyc = cyc;
        last_id     = wb_id_o;
        last_data   = wb_data_o;
        last_exc    = wb_exc_o;
      end
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        chk("wb_valid", wb_valid_o, 1);
        chk("wb_fields", {wb_id_o, wb_data_o, wb_exc_o},
            {exp_q[0].id, exp_q[0].d, exp_q[0].e});
        void'(exp_q.pop_front());
      end else begin
        chk("no_wb", wb_valid_o, 0);
      end
    end
  end

  task automatic give_res(input logic [2:0] id, input logic [63:0] d);
    x_result_valid_i = 1'b1;
    x_result_id_i    = id;
    x_result_data_i  = d;
  endtask

  // Called in the cycle the FSM sits in DONE
  task automatic done_cycle(input logic [2:0] id, input logic [63:0] d,
                            input logic [1:0] e, input int fmode);
    if (fmode == 3) begin
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
    end else begin
      exp_q.push_back('{cyc, id, d, e});
      step();
    end
    chk("done_to_idle", {instr_ready_o, busy_o}, 2'b10);
  endtask

  // fmode: 0 none, 1 flush in ISSUE, 2 flush in WAIT_RES,
  //        3 flush in DONE, 4 flush at the handshake
  task automatic txn(input logic [31:0] ins, input logic [2:0] tid,
                     input logic [191:0] rs, input logic [2:0] rsv,
                     input int rdly, input bit acc, input bit wbk,
                     input logic [2:0] rr, input int rsdly,
                     input int nwrong, input logic [63:0] rdata,
                     input int fmode, input int foff, input int ddly);
    int  exc;
    bit  waits;
    bit  drain;
    chk("idle_ready", {instr_ready_o, busy_o, x_result_ready_o}, 3'b100);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    id_i          = tid;
    rs_i          = rs;
    rs_valid_i    = rsv;
    req_cyc       = cyc;
    step();
    instr_valid_i = 1'b0;
    instr_i       = $urandom;
    id_i          = IDW'($urandom);
    rs_i          = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom};
    rs_valid_i    = 3'($urandom);
    for (int k = 0; k < rdly; k++) begin
      chk("issue_hold",
          {x_issue_valid_o, instr_ready_o, x_result_ready_o,
           x_issue_instr_o, x_issue_id_o, x_issue_rs_valid_o,
           x_issue_rs_o},
          {3'b100, ins, tid, rsv, rs});
      if (fmode == 1 && k == foff) begin
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("issue_flush_idle",
            {instr_ready_o, busy_o, x_issue_valid_o}, 3'b100);
        return;
      end
      step();
    end
    chk("issue_hs",
        {x_issue_valid_o, instr_ready_o, x_result_ready_o,
         x_issue_instr_o, x_issue_id_o, x_issue_rs_valid_o,
         x_issue_rs_o},
        {3'b100, ins, tid, rsv, rs});
    x_issue_ready_i        = 1'b1;
    x_resp_accept_i        = acc;
    x_resp_writeback_i     = wbk;
    x_resp_register_read_i = rr;
    if (fmode == 4) flush_i = 1'b1;
    exc   = !acc ? 1 : ((rr & ~rsv) != 3'b000) ? 2 : 0;
    waits = acc && exc == 0 && wbk;
    step();
    x_issue_ready_i        = 1'b0;
    x_resp_accept_i        = 1'($urandom);
    x_resp_writeback_i     = 1'($urandom);
    x_resp_register_read_i = 3'($urandom);
    flush_i                = 1'b0;
    if (!waits) begin
      if (fmode == 4) begin
        chk("hs_flush_idle", {instr_ready_o, busy_o}, 2'b10);
      end else begin
        chk("done_no_rr", x_result_ready_o, 0);
        done_cycle(tid, 64'h0, 2'(exc), fmode);
      end
      return;
    end
    drain = (fmode == 4);
    if (!drain) begin
      for (int w = 0; w < TMO; w++) begin
        chk("wait_rr", {x_result_ready_o, instr_ready_o,
                        x_issue_valid_o}, 3'b100);
        if (fmode == 2 && w == foff) begin
          flush_i = 1'b1;
          if (w == rsdly) give_res(tid, rdata);
          step();
          flush_i          = 1'b0;
          x_result_valid_i = 1'b0;
          if (w == rsdly) begin
            chk("flush_res_idle", {instr_ready_o, busy_o}, 2'b10);
            return;
          end
          drain = 1'b1;
          break;
        end
        if (w == rsdly) begin
          give_res(tid, rdata);
          step();
          x_result_valid_i = 1'b0;
          done_cycle(tid, rdata, 2'd0, fmode);
          return;
        end
        if (w < nwrong)
          give_res(tid ^ 3'($urandom_range(1, 7)), {$urandom, $urandom});
        step();
        x_result_valid_i = 1'b0;
      end
      if (!drain) begin
        done_cycle(tid, 64'h0, 2'd3, fmode);
        return;
      end
    end
    for (int w = 0; w < TMO; w++) begin
      chk("drain_rr", {x_result_ready_o, instr_ready_o}, 2'b10);
      if (w == ddly) begin
        give_res(tid, rdata);
        step();
        x_result_valid_i = 1'b0;
        chk("drain_res_idle", {instr_ready_o, busy_o}, 2'b10);
        return;
      end
      step();
    end
    chk("drain_tmo_idle", {instr_ready_o, busy_o}, 2'b10);
  endtask

  initial begin
    logic [191:0] rs;
    rst_ni = 1'b0;
    instr_valid_i = 0; instr_i = 0; id_i = 0; rs_i = 0; rs_valid_i = 0;
    flush_i = 0; x_issue_ready_i = 0; x_resp_accept_i = 0;
    x_resp_writeback_i = 0; x_resp_register_read_i = 0;
    x_result_valid_i = 0; x_result_id_i = 0; x_result_data_i = 0;
    repeat (3) step();
    chk("reset_state",
        {instr_ready_o, busy_o, x_issue_valid_o, x_result_ready_o,
         wb_valid_o, wb_id_o, wb_data_o, wb_exc_o, x_issue_instr_o,
         x_issue_id_o, x_issue_rs_valid_o, x_issue_rs_o},
        {1'b1, 256'h0});
    rst_ni = 1'b1;
    step();

    // sha256sig0 with a writeback result three cycles into the wait
    last_wb_cyc = -1;
    txn(32'h10201013, 3'd2, 192'h1, 3'b001, 0, 1, 1, 3'b001,
        2, 0, 64'hDEAD, 0, 0, 9);
    chk("t1_wb", {last_id, last_data, last_exc}, {3'd2, 64'hDEAD, 2'd0});
    chk("t1_latency", last_wb_cyc - req_cyc, 5);
    step();

    // PRNG seed: no writeback
    last_wb_cyc = -1;
    txn(32'h0A00107B, 3'd1, 192'h7, 3'b000, 0, 1, 0, 3'b000,
        9, 0, 64'h0, 0, 0, 9);
    chk("t2_wb", {last_id, last_data, last_exc}, {3'd1, 64'h0, 2'd0});
    chk("t2_latency", last_wb_cyc - req_cyc, 2);

    txn(32'h12345677, 3'd3, 192'h5, 3'b111, 1, 0, 1, 3'b000,
        9, 0, 64'h0, 0, 0, 9);
    chk("t3_illegal", {last_id, last_exc}, {3'd3, 2'd1});
    txn(32'h12345678, 3'd4, 192'h5, 3'b001, 0, 1, 1, 3'b011,
        9, 0, 64'h0, 0, 0, 9);
    chk("t3_operand", {last_id, last_exc}, {3'd4, 2'd2});

    // Issue stalled five cycles, then flushed
    last_wb_cyc = -1;
    txn(32'hCAFE0013, 3'd6, 192'hABC, 3'b011, 6, 1, 1, 3'b001,
        9, 0, 64'h0, 1, 5, 9);
    chk("t4_no_wb", last_wb_cyc, -1);

    txn(32'h22220013, 3'd2, 192'h9, 3'b001, 0, 1, 1, 3'b001,
        1, 1, 64'h42, 0, 0, 9);
    chk("t5_match", {last_id, last_data, last_exc}, {3'd2, 64'h42, 2'd0});
    last_wb_cyc = -1;
    txn(32'h22220013, 3'd2, 192'h9, 3'b001, 0, 1, 1, 3'b001,
        9, 0, 64'h77, 2, 0, 1);
    chk("t5_flush_no_wb", last_wb_cyc, -1);

    txn(32'h33330013, 3'd5, 192'h1, 3'b001, 0, 1, 1, 3'b001,
        9, 0, 64'h0, 0, 0, 9);
    chk("t6_timeout", {last_id, last_data, last_exc}, {3'd5, 64'h0, 2'd3});
    chk("t6_latency", last_wb_cyc - req_cyc, 6);

    for (int n = 0; n < 200; n++) begin
      int r, fm, rdly, foff;
      logic [2:0] rsv;
      rs   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rsv  = 3'($urandom);
      rdly = $urandom_range(0, 4);
      r    = $urandom_range(0, 9);
      fm   = (r < 6) ? 0 : r - 5;
      foff = (fm == 1) ? $urandom_range(0, rdly) : $urandom_range(0, 4);
      txn($urandom, 3'($urandom), rs, rsv, rdly,
          $urandom_range(0, 9) != 0, 1'($urandom),
          3'($urandom) & (($urandom_range(0, 3) != 0) ? rsv : 3'b111),
          $urandom_range(0, 5), $urandom_range(0, 2),
          {$urandom, $urandom}, fm, foff, $urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) step();
    end

    // Reset in the middle of a result wait
    txn(32'h44440013, 3'd1, 192'h3, 3'b011, 0, 1, 1, 3'b001,
        0, 0, 64'h99, 0, 0, 9);
    instr_valid_i = 1'b1; instr_i = 32'h5555_0013; id_i = 3'd7;
    rs_i = 192'h1234; rs_valid_i = 3'b111;
    step();
    instr_valid_i = 1'b0;
    x_issue_ready_i = 1'b1; x_resp_accept_i = 1'b1;
    x_resp_writeback_i = 1'b1; x_resp_register_read_i = 3'b001;
    step();
    x_issue_ready_i = 1'b0;
    step();
    chk("pre_reset_wait", {x_result_ready_o, busy_o}, 2'b11);
    rst_ni = 1'b0;
    step();
    chk("mid_reset_state",
        {instr_ready_o, busy_o, x_issue_valid_o, x_result_ready_o,
         wb_valid_o, wb_id_o, wb_data_o, wb_exc_o, x_issue_instr_o,
         x_issue_id_o, x_issue_rs_valid_o, x_issue_rs_o},
        {1'b1, 256'h0});
    rst_ni = 1'b1;
    step();
    step();
    chk("exp_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
